// File: rtl/xbus_pkg.sv
// Shared definitions for the xbus initiator: state encoding, widths and watchdog default.
package xbus_pkg;

    localparam int TIMEOUT_DEFAULT = 128;
    localparam int ADDR_W          = 22;
    localparam int DATA_W          = 32;
    localparam int LEN_W           = 4;
    localparam int WD_W            = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RSP     = 2'd3;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // Word addresses wrap naturally at the 22-bit boundary.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/xbus_watchdog.sv
// Bus-ack watchdog: down-counter loaded on clear, expires on the TIMEOUT_CYCLES-th enabled cycle.
module xbus_watchdog
    import xbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_W-1:0] LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] ONE  = WD_W'(1);

    logic [WD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - ONE;
        end
    end

    // The load value already accounts for the current cycle, so zero means "last allowed cycle".
    assign expired = enable && (count == '0);

endmodule

// File: rtl/xbus_initiator.sv
// Command-to-bus initiator: read bursts, fill writes, watchdog abort, response backpressure.
module xbus_initiator
    import xbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              bus_req,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dataout,
    input  logic [DATA_W-1:0] bus_datain,
    input  logic              bus_ack
);

    logic [1:0]       state;
    cmd_t             cmd_q;
    logic [LEN_W-1:0] beats_left;
    logic             go_rsp;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;

    // Responses are presented for reads, the final write beat and any abort.
    assign go_rsp    = rsp_err || !cmd_q.write || (beats_left == '0);

    assign wd_clear  = ((state == ST_IDLE)    && cmd_valid)
                    || ((state == ST_RELEASE) && !bus_ack && !go_rsp)
                    || ((state == ST_RSP)     && rsp_ready && !rsp_last);
    assign wd_enable = (state == ST_REQ) && !bus_ack;

    xbus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            beats_left <= '0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q      <= '{write: cmd_write, addr: cmd_addr, data: cmd_data};
                        beats_left <= cmd_len;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack in the expiry cycle still completes the beat normally.
                    if (bus_ack) begin
                        rsp_data <= cmd_q.write ? '0 : bus_datain;
                        rsp_last <= (beats_left == '0);
                        rsp_err  <= 1'b0;
                        state    <= ST_RELEASE;
                    end else if (wd_expired) begin
                        rsp_data <= '0;
                        rsp_last <= 1'b1;
                        rsp_err  <= 1'b1;
                        state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!bus_ack) begin
                        if (go_rsp) begin
                            state <= ST_RSP;
                        end else begin
                            cmd_q.addr <= next_addr(cmd_q.addr);
                            beats_left <= beats_left - LEN_W'(1);
                            state      <= ST_REQ;
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        if (rsp_last) begin
                            state <= ST_IDLE;
                        end else begin
                            cmd_q.addr <= next_addr(cmd_q.addr);
                            beats_left <= beats_left - LEN_W'(1);
                            state      <= ST_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign bus_req     = (state == ST_REQ);
    assign rsp_valid   = (state == ST_RSP);
    assign bus_write   = cmd_q.write;
    assign bus_addr    = cmd_q.addr;
    assign bus_dataout = cmd_q.data;

endmodule

// File: tb/tb_xbus_initiator.sv
// Randomised scoreboard bench for xbus_initiator with a behavioural bus responder.
module tb_xbus_initiator;

    typedef struct {
        logic [21:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          hold;
        bit          noack;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [21:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_write;
    logic [21:0] bus_addr;
    logic [31:0] bus_dataout;
    logic [31:0] bus_datain;
    logic        bus_ack;

    beat_t plan_q[$];
    rsp_t  exp_q[$];
    int    n_cmp      = 0;
    int    n_fail     = 0;
    int    beats_seen = 0;
    bit    stall_req  = 0;
    bit    stray_ok   = 0;
    bit    idle_stray = 0;

    xbus_initiator #(.TIMEOUT_CYCLES(128)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_len     (cmd_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .rsp_err     (rsp_err),
        .bus_req     (bus_req),
        .bus_write   (bus_write),
        .bus_addr    (bus_addr),
        .bus_dataout (bus_dataout),
        .bus_datain  (bus_datain),
        .bus_ack     (bus_ack)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: checks each request against the plan, acks with planned data or withholds.
    initial begin
        beat_t b;
        int    cnt;
        bit    aborted;
        bus_ack    = 0;
        bus_datain = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus_ack = 0;
            end else if (bus_req) begin
                if (plan_q.size() == 0) begin
                    check("unexpected_bus_req", 64'(bus_req), 64'd0);
                end else begin
                    b = plan_q.pop_front();
                    beats_seen++;
                    check("bus_addr", 64'(bus_addr), 64'(b.addr));
                    check("bus_write", 64'(bus_write), 64'(b.write));
                    check("bus_dataout", 64'(bus_dataout), 64'(b.wdata));
                    if (b.noack) begin
                        cnt = 1;
                        aborted = 0;
                        while (cnt < 400) begin
                            @(negedge clk);
                            if (reset) begin
                                aborted = 1;
                                break;
                            end
                            if (!bus_req) break;
                            check("req_stable_noack", {9'd0, bus_write, bus_addr, bus_dataout},
                                  {9'd0, b.write, b.addr, b.wdata});
                            cnt++;
                        end
                        if (!aborted) check("req_hold_cycles", 64'(cnt), 64'd128);
                    end else begin
                        repeat (b.delay) begin
                            @(negedge clk);
                            check("req_stable", {8'd0, bus_req, bus_write, bus_addr, bus_dataout},
                                  {8'd0, 1'b1, b.write, b.addr, b.wdata});
                        end
                        bus_ack    = 1;
                        bus_datain = b.rdata;
                        @(negedge clk);
                        bus_datain = $urandom;
                        check("req_drop_after_ack", {62'd0, bus_req, rsp_valid}, 64'd0);
                        repeat (b.hold) begin
                            @(negedge clk);
                            check("release_wait", {62'd0, bus_req, rsp_valid}, 64'd0);
                        end
                        bus_ack = 0;
                    end
                end
            end else begin
                bus_ack    = stray_ok || idle_stray;
                bus_datain = $urandom;
            end
        end
    end

    // Response monitor: drives rsp_ready, pops the scoreboard on each handshake.
    initial begin
        rsp_t exp;
        rsp_t prev;
        bit   have_prev;
        int   stall_cnt;
        rsp_ready = 0;
        have_prev = 0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_ready = 0;
                have_prev = 0;
                stall_cnt = 0;
                stray_ok  = 0;
            end else begin
                if (rsp_valid) check("no_req_while_rsp", 64'(bus_req), 64'd0);
                if (have_prev) begin
                    check("rsp_held", {30'd0, rsp_valid, rsp_data, rsp_last, rsp_err},
                          {30'd0, 1'b1, prev});
                end
                if (stall_req && rsp_valid) begin
                    stall_req = 0;
                    stall_cnt = 10;
                end
                if (stall_cnt > 0) begin
                    rsp_ready = 0;
                    stray_ok  = (stall_cnt >= 4) && (stall_cnt <= 8);
                    stall_cnt--;
                end else begin
                    stray_ok  = 0;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_valid && rsp_ready) begin
                    have_prev = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("rsp_data", 64'(rsp_data), 64'(exp.data));
                        check("rsp_last", 64'(rsp_last), 64'(exp.last));
                        check("rsp_err", 64'(rsp_err), 64'(exp.err));
                    end
                end else if (rsp_valid) begin
                    have_prev = 1;
                    prev      = {rsp_data, rsp_last, rsp_err};
                end else begin
                    have_prev = 0;
                end
            end
        end
    end

    // Reference model: expand a command into its bus beats and response beats, then offer it.
    task automatic issue(input bit wr, input logic [21:0] addr, input logic [31:0] data,
                         input int len, input int noack, input int dly, input int hld,
                         input bit use_rd, input logic [31:0] rd, input bit expect_reset);
        beat_t b;
        rsp_t  r;
        bit    ok;
        int    nbeats;
        nbeats = (noack >= 0) ? noack + 1 : len + 1;
        for (int i = 0; i < nbeats; i++) begin
            b.addr  = addr + 22'(i);
            b.write = wr;
            b.wdata = data;
            b.rdata = use_rd ? rd : $urandom;
            b.delay = (dly >= 0) ? dly : $urandom_range(0, 4);
            b.hold  = (hld >= 0) ? hld : $urandom_range(0, 3);
            b.noack = (i == noack);
            plan_q.push_back(b);
            if (!wr && (i != noack)) begin
                r.data = b.rdata;
                r.last = (i == len);
                r.err  = 1'b0;
                exp_q.push_back(r);
            end
        end
        if (noack >= 0) begin
            if (!expect_reset) begin
                r = {32'd0, 1'b1, 1'b1};
                exp_q.push_back(r);
            end
        end else if (wr) begin
            r = {32'd0, 1'b1, 1'b0};
            exp_q.push_back(r);
        end
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_ready_wait", 64'(ok), 64'd1);
        cmd_valid = 1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_len   = 4'(len);
        @(negedge clk);
        cmd_valid = 0;
        cmd_write = 1'($urandom);
        cmd_addr  = 22'($urandom);
        cmd_data  = $urandom;
        cmd_len   = 4'($urandom);
        check("req_latency", 64'(bus_req), 64'd1);
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && plan_q.size() == 0 && cmd_ready && !bus_ack) begin
                done = 1;
                break;
            end
        end
        check("cmd_complete", 64'(done), 64'd1);
    endtask

    initial begin
        int          base;
        int          len;
        int          noack;
        logic [21:0] a;
        reset     = 1;
        cmd_valid = 0;
        cmd_write = 0;
        cmd_addr  = 0;
        cmd_data  = 0;
        cmd_len   = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {rsp_valid, rsp_last, rsp_err, bus_req, bus_write, bus_addr, bus_dataout} |
              64'(rsp_data), 64'd0);
        reset = 0;
        @(negedge clk);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        idle_stray = 1;
        repeat (4) begin
            @(negedge clk);
            check("idle_ack_ignored", {61'd0, bus_req, rsp_valid, cmd_ready}, 64'd1);
        end
        idle_stray = 0;
        repeat (2) @(negedge clk);

        issue(0, 22'h000100, $urandom, 0, -1, 3, 0, 1, 32'h12345678, 0);
        wait_done();
        issue(1, 22'h3FFFFE, 32'hA5A5A5A5, 2, -1, -1, -1, 0, 0, 0);
        wait_done();
        stall_req = 1;
        issue(0, 22'($urandom), $urandom, 3, -1, -1, -1, 0, 0, 0);
        wait_done();
        issue(0, 22'($urandom), $urandom, 0, 0, -1, -1, 0, 0, 0);
        wait_done();
        issue(0, 22'($urandom), $urandom, 3, 1, -1, -1, 0, 0, 0);
        wait_done();
        issue(0, 22'($urandom), $urandom, 1, -1, 1, 5, 0, 0, 0);
        wait_done();
        issue(1, 22'($urandom), $urandom, 2, -1, 0, 5, 0, 0, 0);
        wait_done();

        base = beats_seen;
        issue(0, 22'($urandom), $urandom, 3, 1, 2, 0, 0, 0, 1);
        for (int c = 0; c < 500 && beats_seen < base + 2; c++) @(negedge clk);
        check("reached_beat2", 64'(beats_seen), 64'(base + 2));
        check("beat2_in_req", 64'(bus_req), 64'd1);
        reset = 1;
        @(negedge clk);
        check("reset_drops_req", {62'd0, bus_req, rsp_valid}, 64'd0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("cmd_ready_after_midreset", 64'(cmd_ready), 64'd1);
        check("midreset_rsp_drained", 64'(exp_q.size()), 64'd0);
        check("midreset_plan_drained", 64'(plan_q.size()), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("no_rsp_after_reset", {62'd0, rsp_valid, bus_req}, 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            len   = $urandom_range(0, 15);
            noack = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            if ($urandom_range(0, 3) == 0) a = 22'h3FFFFF - 22'($urandom_range(0, 8));
            else a = 22'($urandom);
            issue(1'($urandom), a, $urandom, len, noack, -1, -1, 0, 0, 0);
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xbus_initiator.md
XBUS_INITIATOR -- requirements
Module: xbus_initiator

Interface
REQ-001 Parameters SHALL be, one per line:
  TIMEOUT_CYCLES  128  bus cycles to wait for bus_ack before aborting (range 2..255)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock
  reset  in  1  synchronous, active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1 = write/fill, 0 = read
  cmd_addr  in  22  start word address
  cmd_data  in  32  write/fill data
  cmd_len  in  4  beat count minus 1 (1..16 beats)
  rsp_valid  out  1  response beat available
  rsp_ready  in  1  response beat consumed
  rsp_data  out  32  read data (0 for writes)
  rsp_last  out  1  final beat of command
  rsp_err  out  1  watchdog abort occurred
  bus_req  out  1  bus request
  bus_write  out  1  bus read#/write
  bus_addr  out  22  bus address
  bus_dataout  out  32  bus write data
  bus_datain  in  32  bus read data, valid while bus_ack first rises
  bus_ack  in  1  bus request done

Function
REQ-003 States SHALL be IDLE, REQ, RELEASE, RSP.
REQ-004 cmd_ready SHALL be high exactly when state is IDLE; a handshake latches write, addr, data and len, and moves to REQ next cycle.
REQ-005 In REQ, bus_req SHALL be 1, with bus_addr = current beat address, bus_write = latched write, and bus_dataout = latched data; all four SHALL stay stable until bus_ack.
REQ-006 In the first REQ cycle with bus_ack = 1, the block SHALL capture bus_datain (reads only) into the response register and go to RELEASE; bus_req SHALL be 0 from the next cycle.
REQ-007 RELEASE SHALL hold bus_req low until bus_ack is sampled low, then go to RSP (read beat, last write beat, or error) or directly back to REQ (non-last write beat).
REQ-008 Reads: one rsp beat per bus beat; rsp_last = 1 on beat cmd_len+1.
REQ-009 Writes: cmd_data SHALL be written to cmd_len+1 consecutive addresses (fill); a single rsp beat with rsp_data = 0 and rsp_last = 1 SHALL follow.
REQ-010 In RSP, rsp_valid SHALL be 1 and rsp_* SHALL be held until rsp_ready; on the handshake, go to IDLE if last/error, else to REQ with the address incremented.
REQ-011 No new bus_req SHALL be issued while an unaccepted rsp beat is pending (backpressure stalls the bus).
REQ-012 The beat address SHALL increment modulo 2^22 (3FFFFF wraps to 000000).
REQ-013 The watchdog SHALL count REQ cycles without bus_ack, clearing on each entry to REQ; if the count reaches TIMEOUT_CYCLES, it SHALL drop bus_req, pass through RELEASE, then emit one rsp with rsp_err = 1, rsp_last = 1, and rsp_data = 0, discarding remaining beats.
REQ-014 bus_ack rising in the same cycle the watchdog expires SHALL count as a normal ack (ack wins).
REQ-015 bus_ack high in IDLE or RSP SHALL be ignored.
REQ-016 Latency: cmd handshake at cycle N -> bus_req high at N+1; ack at cycle M -> rsp_valid at the earliest M+2 (RELEASE one cycle with ack low).

Reset
REQ-017 Reset SHALL force state to IDLE and drive bus_req, bus_write, rsp_valid, rsp_last, rsp_err, the watchdog and beat counters, bus_addr, bus_dataout and rsp_data to 0; cmd_ready SHALL be 1 the cycle after reset deasserts.
REQ-018 Reset asserted mid-transaction SHALL drop bus_req at the next edge and discard the command with no response.

Structure
REQ-019 The state encoding and the TIMEOUT_CYCLES default SHALL live in the shared xbus package.
REQ-020 The watchdog SHALL be a sub-module, xbus_watchdog (clear, enable, expired).

Verification
REQ-021 Single read: addr 000100, len 0, responder acks after 3 cycles with 12345678 -> one rsp beat with data 12345678, last = 1, err = 0; bus_req low 1 cycle after the ack.
REQ-022 Fill write: addr 3FFFFE, len 2, data A5A5A5A5 -> bus writes to 3FFFFE, 3FFFFF, 000000, then one rsp with data 0 and last = 1.
REQ-023 Read burst len 3 with rsp_ready low for 10 cycles after beat 1 -> no bus_req during the stall; 4 beats in order, last only on the 4th.
REQ-024 No ack: bus_req held exactly 128 cycles, then dropped -> rsp err = 1, data 0, last = 1; a 4-beat read aborted on beat 2 yields 1 good beat plus 1 error beat.
REQ-025 Reset asserted during REQ of beat 2 -> bus_req 0 next cycle, no rsp_valid, cmd_ready 1 after reset release.
REQ-026 Responder holds ack high 5 cycles after req drops -> block stays in RELEASE, no new bus_req until ack is low.
